// File: rtl/stream_dmux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Optional per-channel packet counters are enabled with STREAM_DMUX_PKT_CNT_EN.
package stream_dmux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam int PKT_CNT_W = 16;

  // Select width never drops below one bit, even for a two-channel build.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_dmux_if.sv
// Stream bundle for stream_dmux: one valid/ready input, CHANNELS valid/ready outputs.
// master is the surrounding environment, slave is the demultiplexer.
interface stream_dmux_if
  import stream_dmux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_width(CHANNELS)
);

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                in_last;
  logic [SEL_W-1:0]    in_sel;
  logic [CHANNELS-1:0] out_valid;
  logic [CHANNELS-1:0] out_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_last;
  logic                sel_err;

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, sel_err
  );

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last, sel_err
  );

endinterface

// File: rtl/stream_dmux_hold.sv
// Single-entry holding register for the demultiplexer output: payload, last flag
// and destination, with a valid/ready handshake toward the selected channel.
module stream_dmux_hold
  import stream_dmux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic [SEL_W-1:0] i_dest,
  input  logic             i_out_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [SEL_W-1:0] o_dest,
  output logic             o_free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic [SEL_W-1:0] r_dest;

  // A load may coincide with the drain of the current beat; the load wins and valid stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_dest  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_dest  <= i_dest;
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_dest  = r_dest;
  assign o_free  = !r_valid || i_out_ready;

endmodule

// File: rtl/stream_dmux.sv
// Registered 1-to-CHANNELS packet demultiplexer; destination latched on the head beat.
// Define STREAM_DMUX_PKT_CNT_EN to add per-channel 16-bit completed-packet counters (pkt_cnt).
module stream_dmux
  import stream_dmux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic clk,
  input  logic rst_n,
  stream_dmux_if.slave bus
`ifdef STREAM_DMUX_PKT_CNT_EN
  ,
  output logic [CHANNELS*PKT_CNT_W-1:0] pkt_cnt
`endif
);

  localparam int SEL_W = sel_width(CHANNELS);

  state_t              r_state;
  state_t              w_nextState;
  logic [SEL_W-1:0]    r_dest;
  logic                r_drop;
  logic                r_selErr;
  logic                w_head;
  logic                w_selOor;
  logic                w_drop;
  logic [SEL_W-1:0]    w_dest;
  logic                w_inReady;
  logic                w_accept;
  logic                w_load;
  logic                w_holdValid;
  logic [WIDTH-1:0]    w_holdData;
  logic                w_holdLast;
  logic [SEL_W-1:0]    w_holdDest;
  logic                w_holdFree;
  logic                w_holdRdy;
  logic [CHANNELS-1:0] w_outValid;

  // Head beats route on the live in_sel; body beats reuse the latched destination.
  assign w_head    = (r_state == IDLE);
  assign w_selOor  = (int'(bus.in_sel) >= CHANNELS);
  assign w_drop    = w_head ? w_selOor : r_drop;
  assign w_dest    = w_head ? bus.in_sel : r_dest;
  assign w_holdRdy = |(w_outValid & bus.out_ready);
  assign w_inReady = w_drop || w_holdFree;
  assign w_accept  = bus.in_valid && w_inReady;
  assign w_load    = w_accept && !w_drop;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept && !bus.in_last) w_nextState = PKT;
      PKT:     if (w_accept && bus.in_last) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dest   <= '0;
      r_drop   <= 1'b0;
      r_selErr <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_selErr <= w_accept && w_head && w_selOor;
      if (w_accept && w_head) begin
        r_dest <= bus.in_sel;
        r_drop <= w_selOor;
      end
    end
  end

  stream_dmux_hold #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_data      (bus.in_data),
    .i_last      (bus.in_last),
    .i_dest      (w_dest),
    .i_out_ready (w_holdRdy),
    .o_valid     (w_holdValid),
    .o_data      (w_holdData),
    .o_last      (w_holdLast),
    .o_dest      (w_holdDest),
    .o_free      (w_holdFree)
  );

  always_comb begin
    w_outValid = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_outValid[k] = w_holdValid && (w_holdDest == SEL_W'(k));
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_data  = w_holdData;
  assign bus.out_last  = w_holdLast;
  assign bus.sel_err   = r_selErr;

`ifdef STREAM_DMUX_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] r_pktCnt [CHANNELS];

  // Dropped packets never reach the holding register, so they are never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) r_pktCnt[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_outValid[k] && bus.out_ready[k] && w_holdLast) begin
          r_pktCnt[k] <= r_pktCnt[k] + PKT_CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pkt_cnt[k*PKT_CNT_W +: PKT_CNT_W] = r_pktCnt[k];
    end
  end
`else
  // Counter-free build: no pkt_cnt port and no counter state.
`endif

endmodule

// File: tb/tb_stream_dmux.sv
// Directed, table-driven bench for stream_dmux: a 4-channel instance for routing,
// backpressure and reset, and a 3-channel instance for the out-of-range drop path.
module tb_stream_dmux;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   failCount;
  int   selErrHighs;

  stream_dmux_if #(.WIDTH(8), .CHANNELS(4)) ifA ();
  stream_dmux_if #(.WIDTH(8), .CHANNELS(3)) ifB ();

`ifdef STREAM_DMUX_PKT_CNT_EN
  logic [63:0] cntA;
  logic [47:0] cntB;
`endif

  stream_dmux #(.WIDTH(8), .CHANNELS(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA)
`ifdef STREAM_DMUX_PKT_CNT_EN
    ,
    .pkt_cnt (cntA)
`endif
  );

  stream_dmux #(.WIDTH(8), .CHANNELS(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB)
`ifdef STREAM_DMUX_PKT_CNT_EN
    ,
    .pkt_cnt (cntB)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inValid;
    logic [7:0] inData;
    logic       inLast;
    logic [1:0] inSel;
    logic [3:0] outReady;
    logic       expInReady;
    logic [3:0] expOutValid;
    logic [7:0] expOutData;
    logic       expOutLast;
    logic       expSelErr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                              input logic [1:0] s, input logic [3:0] r, input logic eir,
                              input logic [3:0] eov, input logic [7:0] eod,
                              input logic eol, input logic ese);
    vec_t t;
    t.inValid = v;  t.inData = d;  t.inLast = l;  t.inSel = s;  t.outReady = r;
    t.expInReady = eir;  t.expOutValid = eov;  t.expOutData = eod;
    t.expOutLast = eol;  t.expSelErr = ese;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    ifA.in_valid  = v.inValid;
    ifA.in_data   = v.inData;
    ifA.in_last   = v.inLast;
    ifA.in_sel    = v.inSel;
    ifA.out_ready = v.outReady;
  endtask

  task automatic driveB(input logic v, input logic [7:0] d, input logic l,
                        input logic [1:0] s, input logic [2:0] r);
    ifB.in_valid  = v;
    ifB.in_data   = d;
    ifB.in_last   = l;
    ifB.in_sel    = s;
    ifB.out_ready = r;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    testsRun = 0;
    failCount = 0;
    selErrHighs = 0;
    applyStimulus(mk(0, 8'h00, 0, 2'd0, 4'b1111, 0, 0, 0, 0, 0));
    driveB(0, 8'h00, 0, 2'd0, 3'b111);

    // Each row: inputs for one cycle, in_ready before the edge, registered outputs after it.
    vecs[0]  = mk(0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h00, 0, 0);
    vecs[1]  = mk(1, 8'h11, 0, 2'd2, 4'b1111, 1, 4'b0100, 8'h11, 0, 0);
    vecs[2]  = mk(1, 8'h22, 0, 2'd1, 4'b1111, 1, 4'b0100, 8'h22, 0, 0);
    vecs[3]  = mk(1, 8'h33, 1, 2'd1, 4'b1111, 1, 4'b0100, 8'h33, 1, 0);
    vecs[4]  = mk(0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h33, 1, 0);
    vecs[5]  = mk(1, 8'h44, 0, 2'd2, 4'b1111, 1, 4'b0100, 8'h44, 0, 0);
    vecs[6]  = mk(1, 8'h55, 0, 2'd0, 4'b1011, 0, 4'b0100, 8'h44, 0, 0);
    vecs[7]  = mk(1, 8'h55, 0, 2'd0, 4'b1011, 0, 4'b0100, 8'h44, 0, 0);
    vecs[8]  = mk(1, 8'h55, 0, 2'd0, 4'b0000, 0, 4'b0100, 8'h44, 0, 0);
    vecs[9]  = mk(1, 8'h55, 0, 2'd0, 4'b1011, 0, 4'b0100, 8'h44, 0, 0);
    vecs[10] = mk(1, 8'h55, 0, 2'd0, 4'b0100, 1, 4'b0100, 8'h55, 0, 0);
    vecs[11] = mk(1, 8'h66, 1, 2'd3, 4'b1111, 1, 4'b0100, 8'h66, 1, 0);
    vecs[12] = mk(0, 8'h00, 0, 2'd0, 4'b1111, 1, 4'b0000, 8'h66, 1, 0);
    vecs[13] = mk(1, 8'hAA, 1, 2'd0, 4'b1111, 1, 4'b0001, 8'hAA, 1, 0);
    vecs[14] = mk(1, 8'hBB, 1, 2'd1, 4'b1111, 1, 4'b0010, 8'hBB, 1, 0);
    vecs[15] = mk(1, 8'hCC, 1, 2'd0, 4'b1111, 1, 4'b0001, 8'hCC, 1, 0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset.out_valid", 32'(ifA.out_valid), 32'h0);
    checkOutput("reset.in_ready", 32'(ifA.in_ready), 32'h1);
    checkOutput("reset.sel_err", 32'(ifA.sel_err), 32'h0);
    checkOutput("reset.out_data", 32'(ifA.out_data), 32'h0);
    checkOutput("reset.out_last", 32'(ifA.out_last), 32'h0);
    checkOutput("reset.B.out_valid", 32'(ifB.out_valid), 32'h0);
`ifdef STREAM_DMUX_PKT_CNT_EN
    checkOutput("reset.cntA", cntA[31:0], 32'h0);
    checkOutput("reset.cntB", cntB[31:0], 32'h0);
`endif

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d.in_ready", i), 32'(ifA.in_ready), 32'(vecs[i].expInReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d.out_valid", i), 32'(ifA.out_valid), 32'(vecs[i].expOutValid));
      checkOutput($sformatf("vec%0d.out_data", i), 32'(ifA.out_data), 32'(vecs[i].expOutData));
      checkOutput($sformatf("vec%0d.out_last", i), 32'(ifA.out_last), 32'(vecs[i].expOutLast));
      checkOutput($sformatf("vec%0d.sel_err", i), 32'(ifA.sel_err), 32'(vecs[i].expSelErr));
    end
    applyStimulus(mk(0, 8'h00, 0, 2'd0, 4'b1111, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("drain.out_valid", 32'(ifA.out_valid), 32'h0);
`ifdef STREAM_DMUX_PKT_CNT_EN
    checkOutput("cntA.ch0", 32'(cntA[15:0]), 32'd2);
    checkOutput("cntA.ch1", 32'(cntA[31:16]), 32'd1);
    checkOutput("cntA.ch2", 32'(cntA[47:32]), 32'd2);
    checkOutput("cntA.ch3", 32'(cntA[63:48]), 32'd0);
`endif

    // Out-of-range head on the 3-channel instance: whole packet swallowed, one sel_err pulse.
    driveB(1, 8'h77, 0, 2'd3, 3'b000);
    #1;
    checkOutput("drop.head.in_ready", 32'(ifB.in_ready), 32'h1);
    @(posedge clk);
    #1;
    if (ifB.sel_err === 1'b1) selErrHighs++;
    checkOutput("drop.head.sel_err", 32'(ifB.sel_err), 32'h1);
    checkOutput("drop.head.out_valid", 32'(ifB.out_valid), 32'h0);
    driveB(1, 8'h88, 1, 2'd0, 3'b000);
    #1;
    checkOutput("drop.tail.in_ready", 32'(ifB.in_ready), 32'h1);
    @(posedge clk);
    #1;
    if (ifB.sel_err === 1'b1) selErrHighs++;
    checkOutput("drop.tail.sel_err", 32'(ifB.sel_err), 32'h0);
    checkOutput("drop.tail.out_valid", 32'(ifB.out_valid), 32'h0);
    driveB(1, 8'h99, 1, 2'd1, 3'b111);
    #1;
    checkOutput("afterdrop.in_ready", 32'(ifB.in_ready), 32'h1);
    @(posedge clk);
    #1;
    if (ifB.sel_err === 1'b1) selErrHighs++;
    checkOutput("afterdrop.out_valid", 32'(ifB.out_valid), 32'b010);
    checkOutput("afterdrop.out_data", 32'(ifB.out_data), 32'h99);
    driveB(0, 8'h00, 0, 2'd0, 3'b111);
    @(posedge clk);
    #1;
    if (ifB.sel_err === 1'b1) selErrHighs++;
    checkOutput("afterdrop.drain", 32'(ifB.out_valid), 32'h0);
    checkOutput("drop.sel_err_pulses", 32'(selErrHighs), 32'd1);
`ifdef STREAM_DMUX_PKT_CNT_EN
    checkOutput("cntB.ch0", 32'(cntB[15:0]), 32'd0);
    checkOutput("cntB.ch1", 32'(cntB[31:16]), 32'd1);
    checkOutput("cntB.ch2", 32'(cntB[47:32]), 32'd0);
`endif

    // Reset in the middle of a packet: the next beat must be treated as a fresh head.
    applyStimulus(mk(1, 8'h5A, 0, 2'd2, 4'b0000, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("midpkt.out_valid", 32'(ifA.out_valid), 32'b0100);
    applyStimulus(mk(0, 8'h00, 0, 2'd2, 4'b0000, 1, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.out_valid", 32'(ifA.out_valid), 32'h0);
    checkOutput("rst.out_data", 32'(ifA.out_data), 32'h0);
    checkOutput("rst.out_last", 32'(ifA.out_last), 32'h0);
`ifdef STREAM_DMUX_PKT_CNT_EN
    checkOutput("rst.cntA.lo", cntA[31:0], 32'h0);
    checkOutput("rst.cntA.hi", cntA[63:32], 32'h0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(mk(1, 8'h6B, 1, 2'd1, 4'b1111, 1, 0, 0, 0, 0));
    #1;
    checkOutput("postrst.in_ready", 32'(ifA.in_ready), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("postrst.out_valid", 32'(ifA.out_valid), 32'b0010);
    checkOutput("postrst.out_data", 32'(ifA.out_data), 32'h6B);
    checkOutput("postrst.out_last", 32'(ifA.out_last), 32'h1);
    applyStimulus(mk(0, 8'h00, 0, 2'd0, 4'b1111, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    checkOutput("postrst.drain", 32'(ifA.out_valid), 32'h0);
`ifdef STREAM_DMUX_PKT_CNT_EN
    checkOutput("postrst.cntA.ch0", 32'(cntA[15:0]), 32'd0);
    checkOutput("postrst.cntA.ch1", 32'(cntA[31:16]), 32'd1);
    checkOutput("postrst.cntA.ch2", 32'(cntA[47:32]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
